reg_access_ctrl: RTL
====================

# reg_access_ctrl

Byte-stream command sequencer that gives a host serial link (UART/SPI byte layer) read/write access to the PID register memory. It parses 2–3 byte commands, drives the memory's single write port and registered read port, and returns one response byte per command. It sits between the link's rx/tx byte handshakes and the `memory` block's `write_enable/w_addr/w_data/r_addr/r_data_o` pins.

## Interface
- `TIMEOUT_CYCLES`, 50000: idle cycles allowed between bytes of one command before it is discarded.
- `NUM_REGS`, 6: number of readable addresses (0..5).
- `NUM_WR_REGS`, 4: writable addresses (0..3, i.e. P, I, D, SP).
- `clk_in` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: command byte from link.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response pending.
- `tx_ready` in 1: link consumes byte when `tx_valid && tx_ready`.
- `write_enable` out 1: one-cycle write strobe to memory.
- `w_addr` out 8: memory write address.
- `w_data` out 8: memory write data.
- `r_addr` out 8: memory read address.
- `r_data_i` in 8: memory `r_data_o` (registered, 1-cycle latency).
- `busy` out 1: state != IDLE.
- `err_pulse` out 1: one-cycle pulse on NAK or timeout.

## Operation
- Commands: write = `0x57, addr, data`; read = `0x52, addr`. Responses: write OK → `0x06`; read OK → register byte; error → `0x15`.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, READ_CAP, RESP.
- `rx_ready` = 1 only in IDLE, GET_ADDR, GET_DATA, and 0 while `reset` is high.
- IDLE: accepted byte `0x57`/`0x52` → GET_ADDR, latching the opcode. Any other byte → RESP with `0x15`, and `err_pulse` fires.
- GET_ADDR, write opcode:
  - `addr < NUM_WR_REGS` → GET_DATA with `w_addr` latched.
  - Otherwise → RESP `0x15` with `err_pulse`. Addresses 4/5 (PID_O, PWM_O) are read-only.
- GET_ADDR, read opcode:
  - `addr < NUM_REGS` → READ_WAIT with `r_addr` latched.
  - Otherwise → RESP `0x15`.
- GET_DATA: accepted byte is latched to `w_data` → WRITE.
- WRITE: `write_enable` = 1 for exactly this cycle → RESP `0x06`.
- READ_WAIT: one cycle, `r_addr` held → READ_CAP.
- READ_CAP: `tx_data <= r_data_i` → RESP.
- RESP: `tx_valid` = 1 and `tx_data` stable until `tx_ready`. The handshake cycle → IDLE, with `tx_valid` = 0 the next cycle.
- Timeout:
  - The counter clears on every accepted byte and counts only in GET_ADDR/GET_DATA.
  - On reaching `TIMEOUT_CYCLES-1` → IDLE, no response, `err_pulse` = 1, no write issued.
- `w_addr`, `w_data`, and `r_addr` hold their last values outside WRITE/READ_WAIT. Only `write_enable` qualifies a write.
- Reset mid-command: returns to IDLE immediately. A pending write is never issued, `tx_valid` drops, and the partial command is lost.

## Timing
- Reset values:
  - `rx_ready`, `tx_valid`, `write_enable`, `err_pulse`, `busy` = 0.
  - `tx_data`, `w_addr`, `w_data`, `r_addr` = 0x00.
  - Internal counter 0, state IDLE.
- Write: data byte accepted in cycle N → `write_enable` high in N+1 → `tx_valid` high in N+2.
- Read: address byte accepted in N → `r_addr` valid in N+1 (memory samples at end of N+1) → `r_data_i` captured at end of N+2 → `tx_valid` in N+3.
- Back-to-back: the next command's first byte can be accepted in the cycle after the response handshake. There is no overlap of commands.
- `tx_ready` held low indefinitely: stay in RESP with no timeout. `rx_ready` stays low throughout.
- `err_pulse` is asserted in the cycle the state transitions on error or timeout.

## Structure
- Shared package `pid_regs_pkg`:
  - Register address constants `REG_P..REG_PWM_O`.
  - Opcode constants `OP_WR=0x57`, `OP_RD=0x52`.
  - Response constants `RSP_ACK=0x06`, `RSP_NAK=0x15`.
  - The state encoding.
- One sub-module, `idle_timer`: a clear/enable counter with terminal-count output, width `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- Write then read back:
  - Send `57 02 A5` → one-cycle `write_enable` with `w_addr`=2, `w_data`=0xA5, then response `06`.
  - Send `52 02` → `r_addr`=2, response `A5` three cycles after the address byte.
- Protected and invalid addresses:
  - `57 04 11` → `15` after the address byte. The data byte is not consumed as part of that command, and `write_enable` never asserts.
  - `52 07` → `15`.
- Bad opcode: `33` → `15` and `err_pulse`. The following `52 00` then completes normally.
- Timeout: send `57 01`, then idle for `TIMEOUT_CYCLES` (set to 16 in the bench) → `err_pulse`, return to IDLE, no response, no write. A subsequent full write succeeds.
- Backpressure: hold `tx_ready`=0 for 20 cycles during a read response → `tx_valid`/`tx_data` stable, `rx_ready`=0. Release → single handshake.
- Reset mid-command: assert `reset` in GET_DATA → all outputs return to reset values next cycle, and no write occurs.

Source files
------------

// File: rtl/pid_regs_pkg.sv
// Shared constants for the PID register map, the host command protocol and
// the command sequencer state encoding.
package pid_regs_pkg;

  localparam logic [7:0] REG_P     = 8'd0;
  localparam logic [7:0] REG_I     = 8'd1;
  localparam logic [7:0] REG_D     = 8'd2;
  localparam logic [7:0] REG_SP    = 8'd3;
  localparam logic [7:0] REG_PID_O = 8'd4;
  localparam logic [7:0] REG_PWM_O = 8'd5;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ_WAIT,
    READ_CAP,
    RESP
  } state_t;

  // States in which the sequencer is willing to take a byte from the link.
  function automatic logic is_rx_state(input state_t s);
    return (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter: clears on demand, counts while enabled and stops
// at its terminal count so the terminal flag stays asserted.
module idle_timer #(
  parameter int TERMINAL = 16,
  parameter int W = (TERMINAL > 2) ? $clog2(TERMINAL) : 1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(TERMINAL - 1));

endmodule

// File: rtl/reg_access_ctrl.sv
// Byte-stream command sequencer giving a host link read/write access to the
// PID register memory, one response byte per command.
module reg_access_ctrl
  import pid_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_REGS       = 6,
  parameter int NUM_WR_REGS    = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       write_enable,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic [7:0] r_addr,
  input  logic [7:0] r_data_i,
  output logic       busy,
  output logic       err_pulse
);

  localparam logic [7:0] RD_LIMIT = 8'(NUM_REGS);
  localparam logic [7:0] WR_LIMIT = 8'(NUM_WR_REGS);

  state_t state;
  logic   op_is_write;
  logic   rx_fire;
  logic   timer_en;
  logic   timeout;

  assign rx_ready = !reset && is_rx_state(state);
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = (state != IDLE);
  assign timer_en = (state == GET_ADDR) || (state == GET_DATA);

  idle_timer #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_in(clk_in),
    .reset (reset),
    .clear (rx_fire || !timer_en),
    .enable(timer_en),
    .tc    (timeout)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      op_is_write  <= 1'b0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      write_enable <= 1'b0;
      w_addr       <= 8'h00;
      w_data       <= 8'h00;
      r_addr       <= 8'h00;
      err_pulse    <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      err_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (rx_data == OP_WR || rx_data == OP_RD) begin
              op_is_write <= (rx_data == OP_WR);
              state       <= GET_ADDR;
            end else begin
              tx_data   <= RSP_NAK;
              tx_valid  <= 1'b1;
              err_pulse <= 1'b1;
              state     <= RESP;
            end
          end
        end
        GET_ADDR: begin
          if (rx_fire) begin
            if (op_is_write && rx_data < WR_LIMIT) begin
              w_addr <= rx_data;
              state  <= GET_DATA;
            end else if (!op_is_write && rx_data < RD_LIMIT) begin
              r_addr <= rx_data;
              state  <= READ_WAIT;
            end else begin
              // Read-only or nonexistent register: the rest of the command
              // is not consumed, the host sees a NAK straight away.
              tx_data   <= RSP_NAK;
              tx_valid  <= 1'b1;
              err_pulse <= 1'b1;
              state     <= RESP;
            end
          end else if (timeout) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            w_data       <= rx_data;
            write_enable <= 1'b1;
            state        <= WRITE;
          end else if (timeout) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end
        end
        WRITE: begin
          tx_data  <= RSP_ACK;
          tx_valid <= 1'b1;
          state    <= RESP;
        end
        READ_WAIT: begin
          state <= READ_CAP;
        end
        READ_CAP: begin
          tx_data  <= r_data_i;
          tx_valid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
